// File: rtl/dmem_arb_pkg.sv
// Shared constants, requester IDs and the round-robin search helper for the
// data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned NREQ_DEF   = 2;
    localparam int unsigned AW_DEF     = 32;
    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned MAX_REQ    = 8;

    localparam int unsigned REQ_CORE   = 0;
    localparam int unsigned REQ_LOADER = 1;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First asserted bit of valid[0..n-1], searching upward from ptr with wrap.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int unsigned        n);
        pick_t       r;
        logic [31:0] j;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !r.found && valid[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer and produces a one-hot grant
// plus the winning index. Nothing is granted while reset is high.
module rr_arbiter import dmem_arb_pkg::*; #(
    parameter int unsigned NREQ = NREQ_DEF,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_found
);

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [MAX_REQ-1:0] valid_ext;
    pick_t              pick;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        pick                  = rr_pick(valid_ext, 3'(ptr_q), NREQ);
        grant_found           = pick.found & ~reset;
        grant_idx             = pick.idx[IW-1:0];
        grant                 = '0;
        ptr_d                 = ptr_q;
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
            ptr_d            = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between NREQ requesters; drives the dmem
// port combinationally and returns a registered ack/read-data one cycle later.
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               mem_we,
    output logic [AW-1:0]      mem_a,
    output logic [DW-1:0]      mem_wd,
    input  logic [DW-1:0]      mem_rd
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            found;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;
    logic            misaligned;

    logic [NREQ-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic            rsp_err_q;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .valid       (req_valid),
        .grant       (grant),
        .grant_idx   (gidx),
        .grant_found (found)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*AW +: AW];
            wdata_arr[i] = req_wdata[i*DW +: DW];
        end
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (found) begin
            sel_addr  = addr_arr[gidx];
            sel_wdata = wdata_arr[gidx];
            sel_we    = req_we[gidx];
        end
        misaligned = found & (sel_addr[1:0] != 2'b00);
        // A misaligned store is acked with an error but must never reach dmem.
        mem_we     = found & sel_we & ~misaligned;
        mem_a      = sel_addr;
        mem_wd     = sel_wdata;
        req_ready  = grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= grant;
            if (found) begin
                rsp_err_q   <= misaligned;
                rsp_rdata_q <= sel_we ? '0 : mem_rd;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem and a response
// scoreboard.
module tb_dmem_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               mem_we;
    logic [AW-1:0]      mem_a;
    logic [DW-1:0]      mem_wd;
    logic [DW-1:0]      mem_rd;

    logic [31:0] ram [0:63];

    typedef struct {
        logic [1:0]  v;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    dmem_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    // Behavioural dmem: combinational word read, write on posedge.
    assign mem_rd = ram[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_we) ram[mem_a[7:2]] <= mem_wd;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive, check the combinational grant/port, then check the ack.
    task automatic step(input string tag, input logic [1:0] v, input logic [1:0] we,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] exp_ready, input logic exp_we,
                        input logic [31:0] exp_rdata);
        rsp_t        e;
        rsp_t        got;
        logic [31:0] ga;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #4;
        ga = exp_ready[0] ? a0 : a1;
        check({tag, " req_ready"}, 64'(req_ready), 64'(exp_ready));
        check({tag, " mem_we"}, 64'(mem_we), 64'(exp_we));
        if (exp_ready == 2'b00) begin
            check({tag, " mem_a idle"}, 64'(mem_a), 64'd0);
        end else begin
            check({tag, " mem_a"}, 64'(mem_a), 64'(ga));
            e.v     = exp_ready;
            e.rdata = exp_rdata;
            e.err   = (ga[1:0] != 2'b00);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(got.v));
            check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(got.rdata));
            check({tag, " rsp_err"}, 64'(rsp_err), 64'(got.err));
        end else begin
            check({tag, " rsp_valid idle"}, 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[0] = 32'd1;
        ram[1] = 32'd1;
        ram[2] = 32'd1;
        ram[3] = 32'd2;

        reset     = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_addr  = {32'h4, 32'h0};
        req_wdata = {32'h77, 32'h66};
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset req_ready", 64'(req_ready), 64'd0);
            check("reset mem_we", 64'(mem_we), 64'd0);
            check("reset rsp_valid", 64'(rsp_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        check("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset rsp_err", 64'(rsp_err), 64'd0);
        check("reset no write", 64'(ram[0]), 64'd1);
        reset = 1'b0;

        // Contention: grants alternate starting with requester 0.
        step("rr0", 2'b11, 2'b00, 32'h0, 32'h4, 0, 0, 2'b01, 1'b0, 32'd1);
        step("rr1", 2'b11, 2'b00, 32'h0, 32'h4, 0, 0, 2'b10, 1'b0, 32'd1);
        step("rr2", 2'b11, 2'b00, 32'h0, 32'h4, 0, 0, 2'b01, 1'b0, 32'd1);
        step("rr3", 2'b11, 2'b00, 32'h0, 32'h4, 0, 0, 2'b10, 1'b0, 32'd1);

        step("ld0_c", 2'b01, 2'b00, 32'hC, 32'h0, 0, 0, 2'b01, 1'b0, 32'd2);

        // Store then read-after-write from requester 1.
        step("st1_8", 2'b10, 2'b10, 32'h0, 32'h8, 0, 32'hDEADBEEF, 2'b10, 1'b1, 32'd0);
        step("ld1_8", 2'b10, 2'b00, 32'h0, 32'h8, 0, 0, 2'b10, 1'b0, 32'hDEADBEEF);

        // Misaligned store: acked with error, memory untouched.
        step("st0_mis", 2'b01, 2'b01, 32'h6, 32'h0, 32'h5, 0, 2'b01, 1'b0, 32'd0);
        step("ld0_4", 2'b01, 2'b00, 32'h4, 32'h0, 0, 0, 2'b01, 1'b0, 32'd1);
        step("ld0_mis", 2'b01, 2'b00, 32'hD, 32'h0, 0, 0, 2'b01, 1'b0, 32'd2);
        step("idle", 2'b00, 2'b00, 32'h0, 32'h0, 0, 0, 2'b00, 1'b0, 32'd0);
        check("idle rdata hold", 64'(rsp_rdata), 64'd2);

        // Reset right after a grant: pending ack dropped, pointer back to 0.
        step("pre_rst", 2'b01, 2'b00, 32'h0, 32'h0, 0, 0, 2'b01, 1'b0, 32'd1);
        reset     = 1'b1;
        req_valid = 2'b11;
        #4;
        check("mid reset req_ready", 64'(req_ready), 64'd0);
        check("mid reset mem_we", 64'(mem_we), 64'd0);
        @(posedge clk);
        #1;
        check("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        step("post_rst0", 2'b11, 2'b00, 32'h8, 32'h0, 0, 0, 2'b01, 1'b0, 32'hDEADBEEF);
        step("post_rst1", 2'b11, 2'b00, 32'h8, 32'h0, 0, 0, 2'b10, 1'b0, 32'd1);
        step("tail", 2'b00, 2'b00, 32'h0, 32'h0, 0, 0, 2'b00, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (`dmem`) between NREQ requesters with fair round-robin arbitration: requester 0 is the core load/store unit, requester 1 is the test/boot loader.
- Grants at most one access per cycle and drives the `dmem` port (`we`, `a`, `wd`, `rd`).
- Returns registered read data and an acknowledge to the winner one cycle after the handshake.
- Sits between the requesters and `dmem`; `dmem` itself is unchanged (combinational read, write on posedge).

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, byte address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester access request.
- req_we  in  NREQ  per-requester write enable (1 = store, 0 = load).
- req_addr  in  NREQ*AW  per-requester byte address; slice i is bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  per-requester store data, sliced the same way.
- req_ready  out  NREQ  grant; handshake occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  one-cycle acknowledge to the requester granted in the previous cycle.
- rsp_rdata  out  DW  registered load data, shared by all requesters (qualified by rsp_valid).
- rsp_err  out  1  misaligned-access flag, valid with rsp_valid.
- mem_we  out  1  to dmem `we`.
- mem_a  out  AW  to dmem `a`.
- mem_wd  out  DW  to dmem `wd`.
- mem_rd  in  DW  from dmem `rd`.

Behaviour:
- Reset values: rr_ptr = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- During reset, req_ready = 0 and mem_we = 0, so no handshake and no write occurs even if req_valid is high.
- Arbitration is combinational within the cycle. Search req_valid starting at index rr_ptr, upward with wrap modulo NREQ. The first asserted index g wins; only req_ready[g] = 1 and all other bits are 0.
- No valid request: req_ready = 0, mem_we = 0, mem_a = 0, mem_wd = 0.
- Grant cycle, port drive: mem_a = req_addr[g] and mem_wd = req_wdata[g].
- Grant cycle, write enable: mem_we = req_we[g] & (req_addr[g][1:0] == 0). A misaligned store never writes.
- Grant edge, pointer update: rr_ptr <= (g + 1) mod NREQ. The pointer is unchanged in cycles with no grant.
- Grant edge, response registers:
  - rsp_valid <= onehot(g).
  - rsp_err <= (req_addr[g][1:0] != 0).
  - rsp_rdata <= req_we[g] ? 0 : mem_rd. Misaligned loads still return word-aligned data (low 2 bits ignored) with rsp_err = 1.
- Without a grant, rsp_valid <= 0 and rsp_rdata / rsp_err hold their values.
- Latency:
  - Loads: response at edge N+1 after the handshake at edge N.
  - Stores: memory is updated at the handshake edge; ack at edge N+1.
  - Throughput is one access per cycle. Back-to-back accesses from the same requester are allowed when it is the only one requesting.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,... A requester waits at most NREQ-1 cycles.
- Read-after-write: a store granted in cycle N followed by a load of the same address in cycle N+1 returns the new data, because dmem writes at the edge and reads combinationally.
- Requester rules:
  - A requester holds req_valid, addr, we and wdata stable until it sees req_ready.
  - Dropping req_valid before grant is permitted; it is simply not served.
  - The arbiter never grants a requester whose req_valid is 0.
- Reset mid-operation: a pending response is discarded (rsp_valid = 0 on the cycle after reset) and rr_ptr returns to 0.

Decomposition:
- Package dmem_arb_pkg holds:
  - default constants NREQ_DEF = 2, AW_DEF = 32, DW_DEF = 32;
  - requester IDs REQ_CORE = 0 and REQ_LOADER = 1;
  - a function rr_pick(valid, ptr) returning the index and a found bit.
- One sub-module, rr_arbiter (NREQ): owns rr_ptr and outputs a one-hot grant plus its index.
- The datapath mux and response registers stay in dmem_arbiter.

Test Plan:
- Reset with dmem preloaded RAM[0..2] = 1, RAM[3] = 2: hold reset 3 cycles with req_valid = 2'b11 -> req_ready = 0, mem_we = 0, rsp_valid = 0 throughout; after release the first grant goes to requester 0.
- Req 0 loads 0xC alone -> req_ready = 2'b01 in the same cycle; next cycle rsp_valid = 2'b01, rsp_rdata = 2, rsp_err = 0.
- Both requesters valid for 4 cycles (loads at 0x0 and 0x4) -> grants 0,1,0,1; rsp_valid 01,10,01,10 lagging by one cycle; each rsp_rdata = 1.
- Req 1 stores 0xDEADBEEF to 0x8, then loads 0x8 in the next cycle -> mem_we = 1 only in the store cycle; load response = 0xDEADBEEF.
- Req 0 stores 0x5 to 0x6 (misaligned) -> mem_we = 0; ack with rsp_err = 1; a later load of 0x4 returns 1 (unchanged).
- Reset asserted the cycle after a grant -> rsp_valid = 0 on the next cycle and rr_ptr = 0, confirmed by req 0 winning the first contested grant after reset.
